// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA scan timing generator: pixel-rate divider, h/v counters and registered sync decode.
// Optional VGA_SYNC_DELAY_EN delays hsync/vsync by one pixel to line up with a registered RGB stage.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned CMP_W    = CNT_W + 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic [CMP_W-1:0] h_nxt_w;
  logic [CMP_W-1:0] v_nxt_w;
  logic             adv_c;
  logic             valid_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             frame_nxt;
  logic             hsync_al;
  logic             vsync_al;

  // Next-state: divider and raster counters, advancing once per pixel
  always_comb begin
    div_nxt = div;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    adv_c   = (div == DIV_W'(CLK_DIV - 1));
    if (adv_c) begin
      div_nxt = '0;
      if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
        h_nxt = '0;
        if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
          v_nxt = '0;
        end else begin
          v_nxt = v_cnt + CNT_W'(1);
        end
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end
    end else begin
      div_nxt = div + DIV_W'(1);
    end
  end

  // Decode from the next counter values so registered flags have zero skew to h_cnt/v_cnt.
  // One extra bit keeps a 1024 total from truncating the compare limits.
  always_comb begin
    h_nxt_w   = {1'b0, h_nxt};
    v_nxt_w   = {1'b0, v_nxt};
    valid_nxt = (h_nxt_w < CMP_W'(H_ACTIVE)) && (v_nxt_w < CMP_W'(V_ACTIVE));
    hsync_nxt = !((h_nxt_w >= CMP_W'(HS_START)) && (h_nxt_w < CMP_W'(HS_END)));
    vsync_nxt = !((v_nxt_w >= CMP_W'(VS_START)) && (v_nxt_w < CMP_W'(VS_END)));
    frame_nxt = adv_c && (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h_cnt       <= CNT_W'(H_TOTAL - 1);
      v_cnt       <= CNT_W'(V_TOTAL - 1);
      valid       <= 1'b0;
      hsync_al    <= 1'b1;
      vsync_al    <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      valid       <= valid_nxt;
      hsync_al    <= hsync_nxt;
      vsync_al    <= vsync_nxt;
      pix_tick    <= adv_c;
      frame_start <= frame_nxt;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Syncs trail the counters by one pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (adv_c) begin
      hsync <= hsync_al;
      vsync <= vsync_al;
    end
  end
`else
  assign hsync = hsync_al;
  assign vsync = vsync_al;
`endif

endmodule
